// File: rtl/hitbox_encoder.sv
// hitbox_encoder: raster scanner emitting a 16x16 hitbox word per slot for every issued pixel.
// Define HITBOX_SHADOW_EN to buffer slot writes in shadow registers committed at frame start.
module hitbox_encoder #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pix_en,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_slot,
    input  logic [9:0]  cfg_x,
    input  logic [9:0]  cfg_y,
    input  logic [4:0]  cfg_level,
    input  logic [8:0]  cfg_id,
    input  logic        cfg_valid,
    output logic        new_frame,
    output logic        new_pixel,
    output logic [22:0] h0_out,
    output logic [22:0] h1_out,
    output logic [22:0] h2_out,
    output logic [22:0] h3_out,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SYNC, GAP, ACTIVE} state_t;
    state_t      r_state;
    logic [9:0]  r_x, r_y, r_pix_x, r_pix_y;
    logic        r_new_frame, r_new_pixel;
    logic [22:0] r_h [4];
    // slot layout: {valid, level[4:0], id[8:0], x[9:0], y[9:0]}
    logic [34:0] r_slot [4];
    logic [34:0] w_cfg;
    logic [22:0] w_word [4];
    logic        w_x_end, w_last;

    assign w_cfg   = {cfg_valid, cfg_level, cfg_id, cfg_x, cfg_y};
    assign w_x_end = r_x == 10'(H_ACTIVE - 1);
    assign w_last  = w_x_end && r_y == 10'(V_ACTIVE - 1);

    function automatic logic [22:0] f_word(input logic [9:0] px, input logic [9:0] py, input logic [34:0] s);
        logic [10:0] w_dx, w_dy;
        logic        w_in;
        w_dx = {1'b0, px} - {1'b0, s[19:10]};
        w_dy = {1'b0, py} - {1'b0, s[9:0]};
        w_in = s[34] && s[28:20] != 9'd0 && px >= s[19:10] && py >= s[9:0] && w_dx <= 11'd15 && w_dy <= 11'd15;
        return w_in ? {s[33:29], s[28:20], w_dx[3:0], w_dy[3:0],
                       w_dx[3:0] == 4'd0 || w_dx[3:0] == 4'd15 || w_dy[3:0] == 4'd0 || w_dy[3:0] == 4'd15} : 23'd0;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) w_word[i] = f_word(r_x, r_y, r_slot[i]);
    end

`ifdef HITBOX_SHADOW_EN
    logic [34:0] r_shadow [4];
    // a write coinciding with SYNC lands in shadow while active takes the old shadow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
                r_slot[i]   <= '0;
            end
        end else begin
            if (cfg_we) r_shadow[cfg_slot] <= w_cfg;
            if (r_state == SYNC) r_slot <= r_shadow;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_slot[i] <= '0;
        end else if (cfg_we) begin
            r_slot[cfg_slot] <= w_cfg;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_new_frame <= 1'b0;
            r_new_pixel <= 1'b0;
            for (int i = 0; i < 4; i++) r_h[i] <= '0;
        end else begin
            r_new_frame <= r_state == SYNC;
            r_new_pixel <= 1'b0;
            case (r_state)
                IDLE:    r_state <= enable ? SYNC : IDLE;
                SYNC: begin
                    r_x     <= '0;
                    r_y     <= '0;
                    r_state <= GAP;
                end
                GAP:     r_state <= ACTIVE;
                default: if (pix_en) begin
                    r_new_pixel <= 1'b1;
                    r_pix_x     <= r_x;
                    r_pix_y     <= r_y;
                    r_h         <= w_word;
                    r_x         <= w_x_end ? 10'd0 : r_x + 10'd1;
                    r_y         <= w_last ? 10'd0 : (w_x_end ? r_y + 10'd1 : r_y);
                    if (w_last) r_state <= enable ? SYNC : IDLE;
                end
            endcase
        end
    end

    assign new_frame = r_new_frame;
    assign new_pixel = r_new_pixel;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign h0_out    = r_h[0];
    assign h1_out    = r_h[1];
    assign h2_out    = r_h[2];
    assign h3_out    = r_h[3];
    assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_hitbox_encoder.sv
// tb_hitbox_encoder: directed checks of raster timing, hitbox words, slot update and reset.
module tb_hitbox_encoder;
    localparam int HA = 112;
    localparam int VA = 56;
`ifdef HITBOX_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif
    logic        clk, rst, en, pe, b_en, b_pe;
    logic        cfg_we, cfg_valid;
    logic [1:0]  cfg_slot;
    logic [9:0]  cfg_x, cfg_y;
    logic [4:0]  cfg_level;
    logic [8:0]  cfg_id;
    logic        a_nf, a_np, a_busy, b_nf, b_np, b_busy;
    logic [22:0] a_h0, a_h1, a_h2, a_h3, b_h0, b_h1, b_h2, b_h3;
    logic [9:0]  a_px, a_py, b_px, b_py;
    int          n_vec = 0;
    int          n_err = 0;

    hitbox_encoder #(.H_ACTIVE(HA), .V_ACTIVE(VA)) dut_a (
        .clk(clk), .rst(rst), .enable(en), .pix_en(pe),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_level(cfg_level), .cfg_id(cfg_id), .cfg_valid(cfg_valid),
        .new_frame(a_nf), .new_pixel(a_np),
        .h0_out(a_h0), .h1_out(a_h1), .h2_out(a_h2), .h3_out(a_h3),
        .pix_x(a_px), .pix_y(a_py), .busy(a_busy)
    );

    hitbox_encoder #(.H_ACTIVE(4), .V_ACTIVE(2)) dut_b (
        .clk(clk), .rst(rst), .enable(b_en), .pix_en(b_pe),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_level(cfg_level), .cfg_id(cfg_id), .cfg_valid(cfg_valid),
        .new_frame(b_nf), .new_pixel(b_np),
        .h0_out(b_h0), .h1_out(b_h1), .h2_out(b_h2), .h3_out(b_h3),
        .pix_x(b_px), .pix_y(b_py), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_wr(input int slot, input int x, input int y, input int lvl, input int id, input bit v);
        cfg_slot = 2'(slot); cfg_x = 10'(x); cfg_y = 10'(y);
        cfg_level = 5'(lvl); cfg_id = 9'(id); cfg_valid = v; cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic run_to(input int x, input int y);
        bit found = 1'b0;
        for (int n = 0; n < 2 * HA * VA + 20 && !found; n++) begin
            @(negedge clk);
            if (a_np && int'(a_px) == x && int'(a_py) == y) found = 1'b1;
        end
        check($sformatf("reach_%0d_%0d", x, y), 32'(found), 32'd1);
    endtask

    // one full frame on dut_a; slot0 anchored at ex_top for row 20, ex_bot for rows 27..36
    task automatic scan(input int ex_top, input int ex_bot, input bit do_wr, input int wx);
        bit done = 1'b0;
        int px, py, h1nz = 0, h3nz = 0, h2nz = 0, mx = 0, my = 0, wrap = 0, ws = 0;
        for (int n = 0; n < 2 * HA * VA + 20 && !done; n++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            if (a_np) begin
                px = int'(a_px);
                py = int'(a_py);
                if (a_h1 != 0) h1nz++;
                if (a_h3 != 0) h3nz++;
                if (a_h2 != 0) begin
                    h2nz++;
                    if (int'(a_h2[8:5]) > mx) mx = int'(a_h2[8:5]);
                    if (int'(a_h2[4:1]) > my) my = int'(a_h2[4:1]);
                    if (px < HA - 8 || py < VA - 8) wrap++;
                end
                if (px == ex_top && py == 20) check("s0_corner", 32'(a_h0), 32'({5'd3, 9'd5, 4'd0, 4'd0, 1'b1}));
                if (px == ex_top + 16 && py == 20) check("s0_right_out", 32'(a_h0), 32'd0);
                if (px == ex_bot + 7 && py == 27) check("s0_center", 32'(a_h0), 32'({5'd3, 9'd5, 4'd7, 4'd7, 1'b0}));
                if (px == ex_bot + 15 && py == 35) check("s0_far", 32'(a_h0), 32'({5'd3, 9'd5, 4'd15, 4'd15, 1'b1}));
                if (px == ex_bot && py == 36) check("s0_below", 32'(a_h0), 32'd0);
                if (px == HA - 8 && py == VA - 8) check("s2_corner", 32'(a_h2), 32'({5'd1, 9'd9, 4'd0, 4'd0, 1'b1}));
                if (px == HA - 1 && py == VA - 1) check("s2_last", 32'(a_h2), 32'({5'd1, 9'd9, 4'd7, 4'd7, 1'b0}));
                if (ws == 2) check("wr_effect", 32'(a_h0), SHADOW ? 32'd0 : 32'({5'd3, 9'd5, 4'd1, 4'd2, 1'b0}));
                if (ws == 1) check("wr_same_edge", 32'(a_h0), 32'd0);
                ws = ws == 0 ? 0 : ws + 1;
                ws = ws > 2 ? 0 : ws;
                if (do_wr && px == 5 && py == 22) begin
                    cfg_slot = 2'd0; cfg_x = 10'(wx); cfg_y = 10'd20;
                    cfg_level = 5'd3; cfg_id = 9'd5; cfg_valid = 1'b1; cfg_we = 1'b1;
                    ws = 1;
                end
                if (px == HA - 1 && py == VA - 1) done = 1'b1;
            end
        end
        check("frame_done", 32'(done), 32'd1);
        check("id0_silent", 32'(h1nz), 32'd0);
        check("unused_silent", 32'(h3nz), 32'd0);
        check("edge_count", 32'(h2nz), 32'd64);
        check("edge_max_x", 32'(mx), 32'd7);
        check("edge_max_y", 32'(my), 32'd7);
        check("edge_nowrap", 32'(wrap), 32'd0);
    endtask

    initial begin
        bit seen;
        int npb, np_cnt, nf_cnt;
        logic [9:0] last_x;
        rst = 1'b1; en = 1'b0; pe = 1'b0; b_en = 1'b0; b_pe = 1'b0;
        cfg_we = 1'b0; cfg_slot = '0; cfg_x = '0; cfg_y = '0; cfg_level = '0; cfg_id = '0; cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_strobes", 32'({a_nf, a_np}), 32'd0);
        check("rst_words", 32'(a_h0 | a_h1 | a_h2 | a_h3), 32'd0);
        check("rst_xy", 32'({a_px, a_py}), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        rst = 1'b0; b_en = 1'b1; b_pe = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("b_strobe_%0d", k), 32'({b_nf, b_np}), 32'({k == 2 || k == 12, k >= 4 && k <= 11}));
            if (k >= 4 && k <= 11) check($sformatf("b_xy_%0d", k), 32'({b_px, b_py}), 32'({10'((k - 4) % 4), 10'((k - 4) / 4)}));
        end
        check("b_busy_run", 32'(b_busy), 32'd1);
        b_en = 1'b0;
        np_cnt = 0; nf_cnt = 0; last_x = '0;
        for (int i = 0; i < 30; i++) begin
            b_pe = !(i == 3 || i == 4);
            @(negedge clk);
            if (i == 3 || i == 4) check($sformatf("b_hold_%0d", i), 32'({b_np, b_px}), 32'({1'b0, last_x}));
            if (b_np) np_cnt++;
            if (b_nf) nf_cnt++;
            last_x = b_px;
        end
        check("b_last_frame_px", 32'(np_cnt), 32'd8);
        check("b_no_new_frame", 32'(nf_cnt), 32'd0);
        check("b_idle", 32'(b_busy), 32'd0);
        cfg_wr(0, 10, 20, 3, 5, 1'b1);
        cfg_wr(1, 30, 5, 7, 0, 1'b1);
        cfg_wr(2, HA - 8, VA - 8, 1, 9, 1'b1);
        en = 1'b1; pe = 1'b1;
        scan(10, 10, 1'b0, 0);
        scan(10, SHADOW ? 10 : 6, 1'b1, 6);
        scan(6, 6, 1'b0, 0);
        run_to(100, 50);
        rst = 1'b1;
        #1;
        check("prst_strobes", 32'({a_nf, a_np}), 32'd0);
        check("prst_busy", 32'(a_busy), 32'd0);
        check("prst_xy", 32'({a_px, a_py}), 32'd0);
        check("prst_words", 32'(a_h0 | a_h1 | a_h2 | a_h3), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0; npb = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (a_np) npb++;
            if (a_nf) seen = 1'b1;
        end
        check("prst_new_frame", 32'(seen), 32'd1);
        check("prst_no_early_px", 32'(npb), 32'd0);
        @(negedge clk);
        check("prst_gap", 32'(a_np), 32'd0);
        @(negedge clk);
        check("prst_first_px", 32'({a_np, a_px, a_py}), 32'({1'b1, 10'd0, 10'd0}));
        run_to(10, 20);
        check("prst_slots_cleared", 32'(a_h0), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
